// File: rtl/backscatter_hop_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// backscatter_hop_ctrl : downlink trigger detect + dual-band hopping uplink burst
// Revision 1.0
// ---------------------------------------------------------------------------
module backscatter_hop_ctrl #(
  parameter int DET_MIN = 100,
  parameter int DET_MAX = 1000,
  parameter int GUARD   = 8,
  parameter int SLOT    = 64,
  parameter int NSLOTS  = 4,
  parameter int COOL    = 32,
  parameter int CW      = 16
) (
  input  logic CLKA,
  input  logic RSTN,
  input  logic SW1,
  input  logic SW2,
  input  logic DEC_IN,
  output logic D901,
  output logic D919,
  output logic ED_EN,
  output logic LED1,
  output logic LED2,
  output logic BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_TX    = 2'd2,
    S_COOL  = 2'd3
  } state_t;

  localparam logic [CW-1:0] c_det_min    = CW'(DET_MIN);
  localparam logic [CW-1:0] c_det_max    = CW'(DET_MAX);
  localparam logic [CW-1:0] c_det_sat    = CW'(DET_MAX + 1);
  localparam logic [CW-1:0] c_guard_last = CW'(GUARD - 1);
  localparam logic [CW-1:0] c_slot       = CW'(SLOT);
  localparam logic [CW-1:0] c_slot_last  = CW'(NSLOTS - 1);
  localparam logic [CW-1:0] c_cool_last  = CW'(COOL - 1);

  state_t        state_q, state_d;
  logic          meta_q, meta_d, dec_s_q, dec_s_d, dec_dly_q, dec_dly_d;
  logic [2:0]    vld_q, vld_d;
  logic          fall_q, fall_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d, tmr_q, tmr_d, slot_q, slot_d;
  logic [1:0]    ch_en_q, ch_en_d;
  logic          d901_q, d901_d, d919_q, d919_d, ed_en_q, ed_en_d;
  logic          led1_q, led1_d, led2_q, led2_d, busy_q, busy_d;
  logic          w_rise, w_use901, w_active;

  always_comb begin
    meta_d    = DEC_IN;
    dec_s_d   = meta_q;
    dec_dly_d = dec_s_q;
    // vld_q[2] marks dec_dly_q as a real post-reset sample, so a level held
    // high across reset release never looks like a rising edge.
    vld_d     = {vld_q[1:0], 1'b1};
    w_rise    = dec_s_q & ~dec_dly_q & vld_q[2];
    fall_d    = ~dec_s_q & dec_dly_q & vld_q[2];

    state_d = state_q;
    tmr_d   = tmr_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    ch_en_d = ch_en_q;

    case (state_q)
      S_IDLE: begin
        if (fall_q) begin
          if (armed_q && (cnt_q >= c_det_min) && (cnt_q <= c_det_max)) begin
            state_d = S_GUARD;
            ch_en_d = {SW2, SW1};
            tmr_d   = '0;
            cnt_d   = '0;
            armed_d = 1'b0;
          end else begin
            cnt_d   = w_rise ? CW'(1) : '0;
            armed_d = w_rise;
          end
        end else if (w_rise) begin
          cnt_d   = CW'(1);
          armed_d = 1'b1;
        end else if (armed_q && dec_s_q && (cnt_q != c_det_sat)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GUARD: begin
        if (tmr_q == c_guard_last) begin
          tmr_d   = '0;
          slot_d  = '0;
          state_d = (ch_en_q != 2'b00) ? S_TX : S_COOL;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_TX: begin
        // tmr 0..SLOT-1 is the active part of a slot, tmr == SLOT the dead cycle
        if (tmr_q == c_slot) begin
          tmr_d = '0;
          if (slot_q == c_slot_last) state_d = S_COOL;
          else                       slot_d  = slot_q + 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_COOL: begin
        if (tmr_q == c_cool_last) begin
          state_d = S_IDLE;
          tmr_d   = '0;
          cnt_d   = '0;
          armed_d = 1'b0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    w_use901 = (ch_en_d == 2'b01) || ((ch_en_d == 2'b11) && !slot_d[0]);
    w_active = (state_d == S_TX) && (tmr_d < c_slot);
    d901_d   = w_active && w_use901;
    d919_d   = w_active && !w_use901;
    ed_en_d  = (state_d == S_IDLE);
    led1_d   = (state_d == S_GUARD) || (state_d == S_TX);
    busy_d   = (state_d != S_IDLE);
    led2_d   = led2_q ^ ((state_q == S_TX) && (state_d == S_COOL));
  end

  always_ff @(posedge CLKA or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      meta_q    <= 1'b0;
      dec_s_q   <= 1'b0;
      dec_dly_q <= 1'b0;
      vld_q     <= '0;
      fall_q    <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      slot_q    <= '0;
      ch_en_q   <= '0;
      d901_q    <= 1'b0;
      d919_q    <= 1'b0;
      ed_en_q   <= 1'b0;
      led1_q    <= 1'b0;
      led2_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      meta_q    <= meta_d;
      dec_s_q   <= dec_s_d;
      dec_dly_q <= dec_dly_d;
      vld_q     <= vld_d;
      fall_q    <= fall_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      slot_q    <= slot_d;
      ch_en_q   <= ch_en_d;
      d901_q    <= d901_d;
      d919_q    <= d919_d;
      ed_en_q   <= ed_en_d;
      led1_q    <= led1_d;
      led2_q    <= led2_d;
      busy_q    <= busy_d;
    end
  end

  assign D901  = d901_q;
  assign D919  = d919_q;
  assign ED_EN = ed_en_q;
  assign LED1  = led1_q;
  assign LED2  = led2_q;
  assign BUSY  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_backscatter_hop_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_backscatter_hop_ctrl : randomized pulses checked against a timeline model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_backscatter_hop_ctrl;

  localparam int DET_MIN = 100;
  localparam int DET_MAX = 1000;
  localparam int GUARD   = 8;
  localparam int SLOT    = 64;
  localparam int NSLOTS  = 4;
  localparam int COOL    = 32;
  localparam int CW      = 16;
  localparam int BURST   = NSLOTS * (SLOT + 1);
  localparam int TAIL    = 4 + GUARD + BURST + COOL + 4;

  logic CLKA, RSTN, SW1, SW2, DEC_IN;
  logic D901, D919, ED_EN, LED1, LED2, BUSY;

  backscatter_hop_ctrl #(
    .DET_MIN(DET_MIN), .DET_MAX(DET_MAX), .GUARD(GUARD), .SLOT(SLOT),
    .NSLOTS(NSLOTS), .COOL(COOL), .CW(CW)
  ) dut (
    .CLKA(CLKA), .RSTN(RSTN), .SW1(SW1), .SW2(SW2), .DEC_IN(DEC_IN),
    .D901(D901), .D919(D919), .ED_EN(ED_EN), .LED1(LED1), .LED2(LED2), .BUSY(BUSY)
  );

  initial CLKA = 1'b0;
  always #25 CLKA = ~CLKA;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int edge_n = 0;
  // Model: the edge at which ED_EN falls for the pending trigger (-1 = none),
  // the latched channel mask and the LED2 level before that burst.
  int       trig_edge = -1;
  logic [1:0] ch = 2'b00;
  logic     led2_base = 1'b0;

  // Expected {D901,D919,ED_EN,LED1,LED2,BUSY} after posedge number e.
  function automatic logic [5:0] model(int e);
    int t, slot, pos, blen;
    logic use901, act, l2;
    if (trig_edge < 0 || e < trig_edge) return {3'b001, 1'b0, led2_base, 1'b0};
    t = e - trig_edge;
    if (t < GUARD) return {3'b000, 1'b1, led2_base, 1'b1};
    t = t - GUARD;
    blen = (ch != 2'b00) ? BURST : 0;
    if (t < blen) begin
      slot   = t / (SLOT + 1);
      pos    = t % (SLOT + 1);
      act    = (pos < SLOT);
      use901 = (ch == 2'b01) || (ch == 2'b11 && (slot % 2) == 0);
      return {act && use901, act && !use901, 1'b0, 1'b1, led2_base, 1'b1};
    end
    t  = t - blen;
    l2 = led2_base ^ (ch != 2'b00);
    if (t < COOL) return {3'b000, 1'b0, l2, 1'b1};
    return {3'b001, 1'b0, l2, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {D901, D919, ED_EN, LED1, LED2, BUSY};
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%b expected=%b (D901,D919,ED_EN,LED1,LED2,BUSY)",
             tag, edge_n, obs, exp);
    end
  endtask

  task automatic tick(input logic d);
    DEC_IN = d;
    @(posedge CLKA);
    edge_n++;
    #1;
    chk("cycle", model(edge_n));
  endtask

  task automatic finalize();
    if (trig_edge >= 0) begin
      if (ch != 2'b00) led2_base = ~led2_base;
      trig_edge = -1;
    end
  endtask

  task automatic pulse(input int w, input logic s1, input logic s2, input bit scramble);
    bit ok;
    SW1 = s1;
    SW2 = s2;
    for (int i = 0; i < w; i++) tick(1'b1);
    ok = (w >= DET_MIN) && (w <= DET_MAX);
    if (ok) begin
      trig_edge = edge_n + 4;
      ch        = {s2, s1};
    end
    for (int i = 0; i < TAIL; i++) begin
      tick(1'b0);
      if (scramble && ok && edge_n > trig_edge + 2) begin
        SW1 = 1'($urandom);
        SW2 = 1'($urandom);
      end
    end
    finalize();
  endtask

  initial begin
    int w, target;
    RSTN = 1'b0; SW1 = 1'b0; SW2 = 1'b0; DEC_IN = 1'b0;
    #60;
    chk("reset_values", 6'b000000);
    @(posedge CLKA); edge_n++; #5;
    RSTN = 1'b1;
    tick(1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0);

    pulse(600, 1'b1, 1'b1, 1'b0);
    pulse(600, 1'b1, 1'b0, 1'b0);
    pulse(50, 1'b1, 1'b1, 1'b0);
    pulse(1500, 1'b1, 1'b1, 1'b0);
    pulse(600, 1'b1, 1'b1, 1'b1);
    pulse(600, 1'b0, 1'b0, 1'b0);
    pulse(600, 1'b0, 1'b1, 1'b1);
    pulse(DET_MIN - 1, 1'b1, 1'b1, 1'b0);
    pulse(DET_MIN, 1'($urandom), 1'($urandom), 1'b0);
    pulse(DET_MAX, 1'($urandom), 1'($urandom), 1'b0);
    pulse(DET_MAX + 1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      w = int'($urandom_range(1100, 40));
      pulse(w, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset in slot 2, with DEC_IN held high across release
    SW1 = 1'b1; SW2 = 1'b1;
    for (int i = 0; i < 600; i++) tick(1'b1);
    trig_edge = edge_n + 4;
    ch        = 2'b11;
    target    = trig_edge + GUARD + 2 * (SLOT + 1) + 10;
    while (edge_n < target) tick(1'b0);
    #5 RSTN = 1'b0; DEC_IN = 1'b1;
    #1 chk("rst_async", 6'b000000);
    trig_edge = -1;
    led2_base = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLKA); edge_n++; #1;
      chk("rst_hold", 6'b000000);
    end
    #5 RSTN = 1'b1;
    for (int i = 0; i < 400; i++) tick(1'b1);
    for (int i = 0; i < TAIL; i++) tick(1'b0);
    pulse(600, 1'b1, 1'b1, 1'b0);

    // Pulse started in COOL, released in IDLE: must not trigger
    SW1 = 1'b1; SW2 = 1'b1;
    for (int i = 0; i < 600; i++) tick(1'b1);
    trig_edge = edge_n + 4;
    ch        = 2'b11;
    target    = trig_edge + GUARD + BURST + 10;
    while (edge_n < target) tick(1'b0);
    for (int i = 0; i < 150; i++) tick(1'b1);
    for (int i = 0; i < 40; i++) tick(1'b0);
    finalize();
    pulse(600, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/backscatter_hop_ctrl.md
Name: backscatter_hop_ctrl

Overview:
- Sequences the dual-band backscatter front end.
- Listens on the envelope detector for a valid downlink trigger pulse, then disables the detector.
- After a guard interval, runs a fixed-length uplink burst that hops between the 901 MHz and 919 MHz switch paths.
- Sits between the switch inputs and envelope-detector input at top level and the D901/D919/ED_EN/LED outputs.

Parameters:
- DET_MIN, 100: minimum valid trigger pulse width, in CLKA cycles (synchronised high time).
- DET_MAX, 1000: maximum valid trigger pulse width, in CLKA cycles.
- GUARD, 8: cycles between detector disable and first slot.
- SLOT, 64: active cycles per hop slot.
- NSLOTS, 4: slots per burst.
- COOL, 32: cycles after a burst before listening again.
- CW, 16: width of internal counters; all count parameters must be < 2^CW.

Ports:
- CLKA  in  1  system clock, 20 MHz.
- RSTN  in  1  asynchronous active-low reset.
- SW1  in  1  enable for the 901 MHz channel (static level).
- SW2  in  1  enable for the 919 MHz channel (static level).
- DEC_IN  in  1  envelope-detector comparator output; asynchronous to CLKA.
- D901  out  1  drive the 901 MHz backscatter switch.
- D919  out  1  drive the 919 MHz backscatter switch.
- ED_EN  out  1  envelope detector enable.
- LED1  out  1  high while a burst is in progress (GUARD or TX).
- LED2  out  1  toggles on each completed burst.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, CLKA; RSTN is asynchronous and active-low. All flops reset immediately on RSTN low, including mid-burst.
- Reset values: D901=0, D919=0, ED_EN=0, LED1=0, LED2=0, BUSY=0. FSM resets to IDLE with counters at 0.
- ED_EN rises on the first CLKA edge after RSTN deasserts.
- All outputs are registered, decoded from the next state.
- DEC_IN passes through a 2-flop synchroniser to give dec_s. Edges are detected on dec_s against its 1-cycle delayed copy.
- IDLE:
  - ED_EN=1.
  - Pulse counter clears, then starts counting only on a dec_s rising edge, so a pulse already high on entry is ignored.
  - Counter increments each cycle dec_s=1 and saturates at DET_MAX+1.
  - On a dec_s falling edge, if DET_MIN <= count <= DET_MAX, go to GUARD; otherwise clear and stay in IDLE.
- GUARD:
  - ED_EN=0, LED1=1, BUSY=1.
  - SW1/SW2 are latched into ch_en[1:0] on entry.
  - After GUARD cycles, go to TX if ch_en != 0, otherwise go to COOL with LED2 unchanged.
- TX:
  - Each slot is SLOT cycles with the selected switch high, followed by 1 dead cycle with both low (break-before-make).
  - With both channels enabled, slot 0 uses D901 and slots then alternate 901, 919, 901, ...
  - With one channel enabled, that channel is used for every slot.
  - After the dead cycle of slot NSLOTS-1, go to COOL and toggle LED2.
  - D901 and D919 are never high in the same cycle.
  - SW1/SW2 changes during a burst are ignored.
- COOL:
  - ED_EN=0, LED1=0, BUSY=1.
  - After COOL cycles, go to IDLE; ED_EN=1 from the entry edge.
- DEC_IN activity outside IDLE is ignored and does not queue a trigger.
- Latency: ED_EN falls on the 4th CLKA rising edge after DEC_IN falls (2 sync, 1 edge detect, 1 output register). D901/D919 first rises GUARD cycles after that.
- Burst length with ch_en != 0: GUARD + NSLOTS*(SLOT+1) cycles of LED1=1.

Test Plan:
- Reset, SW1=1, SW2=1, DEC_IN 600-cycle pulse -> ED_EN falls 4 edges after the fall. After 8 cycles: D901 high 64 cycles, 1 dead cycle, D919 high 64 cycles, then 901, then 919. LED2 toggles 0->1. ED_EN returns 32 cycles later.
- SW1=1, SW2=0 with a 600-cycle trigger -> four 64-cycle D901 slots with dead cycles between; D919 stays 0 throughout.
- Pulses of 50 cycles and 1500 cycles -> no state change; BUSY=0, ED_EN stays 1. A subsequent 600-cycle pulse triggers normally.
- SW1=SW2=0 with a valid trigger -> GUARD then COOL; D901/D919 never assert, LED2 unchanged, ED_EN back to 1 after 8+32 cycles.
- RSTN low during slot 2 -> all outputs 0 within the same cycle. After release, ED_EN=1 on the next edge. DEC_IN held high at release is not counted until its next rising edge.
- Second valid pulse issued during COOL -> ignored. A 600-cycle pulse after return to IDLE produces a full burst, and LED2 toggles back to 0.
